// File: rtl/pio_sw_pkg.sv
// Shared types and slave register map for the switch-PIO IRQ servicer.
package pio_sw_pkg;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_E_ADDR  = 3'd2,
        ST_E_CAP   = 3'd3,
        ST_CLEAR   = 3'd4,
        ST_D_ADDR  = 3'd5,
        ST_D_CAP   = 3'd6,
        ST_PRESENT = 3'd7
    } state_e;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    typedef struct packed {
        logic [1:0] address;
        logic       chipselect;
        logic       write_n;
    } bus_ctl_t;

    localparam bus_ctl_t BUS_IDLE = '{address: PIO_ADDR_DATA, chipselect: 1'b0, write_n: 1'b1};

    // Moore bus controls for each state; write data is handled separately.
    function automatic bus_ctl_t bus_ctl_of(state_e s);
        bus_ctl_t c;
        c = BUS_IDLE;
        case (s)
            ST_INIT:             c = '{address: PIO_ADDR_MASK, chipselect: 1'b1, write_n: 1'b0};
            ST_E_ADDR, ST_E_CAP: c = '{address: PIO_ADDR_EDGE, chipselect: 1'b1, write_n: 1'b1};
            ST_CLEAR:            c = '{address: PIO_ADDR_EDGE, chipselect: 1'b1, write_n: 1'b0};
            ST_D_ADDR, ST_D_CAP: c = '{address: PIO_ADDR_DATA, chipselect: 1'b1, write_n: 1'b1};
            default:             c = BUS_IDLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pio_sw_irq_servicer.sv
// Hardware servicer for the switch PIO: programs the IRQ mask, reads and clears
// edge capture on irq, reads the live switch value and emits one event record.
module pio_sw_irq_servicer
    import pio_sw_pkg::*;
#(
    parameter int unsigned      WIDTH     = 10,
    parameter logic [WIDTH-1:0] INIT_MASK = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [1:0]       pio_address,
    output logic             pio_chipselect,
    output logic             pio_write_n,
    output logic [31:0]      pio_writedata,
    input  logic [31:0]      pio_readdata,
    input  logic             pio_irq,
    input  logic             mask_wr,
    input  logic [WIDTH-1:0] mask_data,
    output logic             mask_busy,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_edges,
    output logic [WIDTH-1:0] evt_data,
    output logic [7:0]       evt_count,
    output state_e           dbg_state_o
);

    // Event handshake: a record transfers on a clock edge where evt_valid and
    // evt_ready are both high; evt_valid never drops and evt_edges/evt_data
    // never change until that transfer, and evt_valid does not wait on evt_ready.

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edges_q, edges_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [7:0]       count_q, count_d;
    logic             valid_q, valid_d;
    bus_ctl_t         bus_q, bus_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             init_on_bus;
    logic             unused_readdata;

    // INIT leaves only once its write has actually been presented, so the first
    // cycle after reset (bus still at reset values) keeps the block in INIT.
    assign init_on_bus = bus_q.chipselect && !bus_q.write_n
                         && (bus_q.address == PIO_ADDR_MASK);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        edges_d = edges_q;
        data_d  = data_q;
        count_d = count_q;
        case (state_q)
            ST_INIT: begin
                if (init_on_bus) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (mask_wr) begin
                    mask_d  = mask_data;
                    state_d = ST_INIT;
                end else if (pio_irq) begin
                    state_d = ST_E_ADDR;
                end
            end
            ST_E_ADDR: state_d = ST_E_CAP;
            ST_E_CAP: begin
                edges_d = pio_readdata[WIDTH-1:0] & mask_q;
                state_d = ST_CLEAR;
            end
            ST_CLEAR:  state_d = ST_D_ADDR;
            ST_D_ADDR: state_d = ST_D_CAP;
            ST_D_CAP: begin
                data_d  = pio_readdata[WIDTH-1:0];
                state_d = (edges_q == '0) ? ST_IDLE : ST_PRESENT;
            end
            ST_PRESENT: begin
                if (evt_ready) begin
                    count_d = count_q + 8'd1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // Outputs are registered from the next state so they line up with it.
        bus_d   = bus_ctl_of(state_d);
        valid_d = (state_d == ST_PRESENT);
        wdata_d = '0;
        if (state_d == ST_INIT) wdata_d[WIDTH-1:0] = mask_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            mask_q  <= INIT_MASK;
            edges_q <= '0;
            data_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            bus_q   <= BUS_IDLE;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            edges_q <= edges_d;
            data_q  <= data_d;
            count_q <= count_d;
            valid_q <= valid_d;
            bus_q   <= bus_d;
            wdata_q <= wdata_d;
        end
    end

    assign pio_address     = bus_q.address;
    assign pio_chipselect  = bus_q.chipselect;
    assign pio_write_n     = bus_q.write_n;
    assign pio_writedata   = wdata_q;
    assign mask_busy       = (state_q != ST_IDLE);
    assign evt_valid       = valid_q;
    assign evt_edges       = edges_q;
    assign evt_data        = data_q;
    assign evt_count       = count_q;
    assign dbg_state_o     = state_q;
    // Bits above WIDTH in readdata carry nothing for this slave.
    assign unused_readdata = ^pio_readdata;

endmodule
